cfg_shadow_loader: RTL and testbench

Configuration sequencer that holds a four-entry shadow bank of per-instance configuration words and streams it into a downstream configurable module over a valid/ready write channel. Reset values of the shadow words are the parameters `VALUE_0`..`VALUE_3`, so parent modules can override them with `#()` or hierarchical `defparam`. The block sits between a control interface (start pulse, override writes) and a target register block. It re-sequences the target whenever configuration changes.

---
 rtl/cfg_shadow_loader_if.sv | 24 ++
 rtl/cfg_shadow_loader.sv | 111 +++++++++++
 tb/tb_cfg_shadow_loader.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cfg_shadow_loader_if.sv
// Configuration write channel between the shadow loader and its target.
// The master presents addr/data beats under valid; the slave accepts with ready.
interface cfg_shadow_loader_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [1:0]            cfg_addr;
    logic [DATA_WIDTH-1:0] cfg_data;

    modport master (
        output cfg_valid,
        output cfg_addr,
        output cfg_data,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_addr,
        input  cfg_data,
        output cfg_ready
    );
endinterface

// File: rtl/cfg_shadow_loader.sv
// Four-word configuration shadow bank streamed to a target register block.
// Starts and overrides are latched into pending and served one cycle later.
module cfg_shadow_loader #(
    parameter int          DATA_WIDTH = 32,
    parameter int unsigned VALUE_0    = 5,
    parameter int unsigned VALUE_1    = 9,
    parameter int unsigned VALUE_2    = 0,
    parameter int unsigned VALUE_3    = 0,
    parameter int          AUTO_START = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  ovr_we,
    input  logic [1:0]            ovr_addr,
    input  logic [DATA_WIDTH-1:0] ovr_data,
    cfg_shadow_loader_if.master   cfg,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            load_count
);
    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    localparam logic [DATA_WIDTH-1:0] DEFAULTS [4] = '{
        DATA_WIDTH'(VALUE_0),
        DATA_WIDTH'(VALUE_1),
        DATA_WIDTH'(VALUE_2),
        DATA_WIDTH'(VALUE_3)
    };

    state_t                state;
    logic [DATA_WIDTH-1:0] shadow    [4];
    logic [DATA_WIDTH-1:0] shadow_nx [4];
    logic                  pending;
    logic                  auto_flag;
    logic [1:0]            nxt_idx;
    logic                  hs;

    // Write-through view so a beat loaded alongside an override carries it.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            shadow_nx[i] = shadow[i];
            if (ovr_we && ovr_addr == 2'(i)) begin
                shadow_nx[i] = ovr_data;
            end
        end
    end

    assign nxt_idx = cfg.cfg_addr + 2'd1;
    assign hs      = cfg.cfg_valid & cfg.cfg_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            for (int i = 0; i < 4; i++) begin
                shadow[i] <= DEFAULTS[i];
            end
            cfg.cfg_valid <= 1'b0;
            cfg.cfg_addr  <= 2'd0;
            cfg.cfg_data  <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            load_count    <= 8'd0;
            pending       <= 1'b0;
            auto_flag     <= (AUTO_START != 0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                shadow[i] <= shadow_nx[i];
            end
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pending || auto_flag) begin
                        state         <= SEND;
                        pending       <= 1'b0;
                        auto_flag     <= 1'b0;
                        busy          <= 1'b1;
                        cfg.cfg_valid <= 1'b1;
                        cfg.cfg_addr  <= 2'd0;
                        cfg.cfg_data  <= shadow_nx[0];
                    end else if (start || ovr_we) begin
                        pending <= 1'b1;
                    end
                end
                SEND: begin
                    if (start || ovr_we) begin
                        pending <= 1'b1;
                    end
                    if (hs) begin
                        if (cfg.cfg_addr == 2'd3) begin
                            state         <= IDLE;
                            busy          <= 1'b0;
                            cfg.cfg_valid <= 1'b0;
                            done          <= 1'b1;
                            if (load_count != 8'hFF) begin
                                load_count <= load_count + 8'd1;
                            end
                        end else begin
                            cfg.cfg_addr <= nxt_idx;
                            cfg.cfg_data <= shadow_nx[nxt_idx];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cfg_shadow_loader.sv
// Directed bench for cfg_shadow_loader: default, overridden and manual-start
// instances driven through a linear sequence of hand-computed steps.
module tb_cfg_shadow_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    // Instance A: defaults, auto start
    logic        start_a = 1'b0;
    logic        ovr_we_a = 1'b0;
    logic [1:0]  ovr_addr_a = 2'd0;
    logic [31:0] ovr_data_a = 32'd0;
    logic        busy_a, done_a;
    logic [7:0]  lc_a;
    cfg_shadow_loader_if #(.DATA_WIDTH(32)) if_a ();

    cfg_shadow_loader dut_a (
        .clk(clk), .rst(rst), .start(start_a),
        .ovr_we(ovr_we_a), .ovr_addr(ovr_addr_a), .ovr_data(ovr_data_a),
        .cfg(if_a), .busy(busy_a), .done(done_a), .load_count(lc_a)
    );

    // Instance B: parent overrides of the first two words
    logic        busy_b, done_b;
    logic [7:0]  lc_b;
    cfg_shadow_loader_if #(.DATA_WIDTH(32)) if_b ();

    cfg_shadow_loader #(.VALUE_0(7), .VALUE_1(33)) dut_b (
        .clk(clk), .rst(rst), .start(1'b0),
        .ovr_we(1'b0), .ovr_addr(2'd0), .ovr_data(32'd0),
        .cfg(if_b), .busy(busy_b), .done(done_b), .load_count(lc_b)
    );

    // Instance C: manual start
    logic        start_c = 1'b0;
    logic        ovr_we_c = 1'b0;
    logic [1:0]  ovr_addr_c = 2'd0;
    logic [31:0] ovr_data_c = 32'd0;
    logic        busy_c, done_c;
    logic [7:0]  lc_c;
    cfg_shadow_loader_if #(.DATA_WIDTH(32)) if_c ();

    cfg_shadow_loader #(.AUTO_START(0)) dut_c (
        .clk(clk), .rst(rst), .start(start_c),
        .ovr_we(ovr_we_c), .ovr_addr(ovr_addr_c), .ovr_data(ovr_data_c),
        .cfg(if_c), .busy(busy_c), .done(done_c), .load_count(lc_c)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic beat_a(input string tag, input logic [1:0] a,
                          input logic [31:0] d);
        chk({tag, ".valid"}, 32'(if_a.cfg_valid), 32'd1);
        chk({tag, ".addr"}, 32'(if_a.cfg_addr), 32'(a));
        chk({tag, ".data"}, if_a.cfg_data, d);
    endtask

    task automatic beat_c(input string tag, input logic [1:0] a,
                          input logic [31:0] d);
        chk({tag, ".valid"}, 32'(if_c.cfg_valid), 32'd1);
        chk({tag, ".addr"}, 32'(if_c.cfg_addr), 32'(a));
        chk({tag, ".data"}, if_c.cfg_data, d);
    endtask

    initial begin
        if_a.cfg_ready = 1'b1;
        if_b.cfg_ready = 1'b1;
        if_c.cfg_ready = 1'b1;
        tick();
        tick();
        chk("rst.valid", 32'(if_a.cfg_valid), 32'd0);
        chk("rst.addr", 32'(if_a.cfg_addr), 32'd0);
        chk("rst.data", if_a.cfg_data, 32'd0);
        chk("rst.busy", 32'(busy_a), 32'd0);
        chk("rst.done", 32'(done_a), 32'd0);
        chk("rst.lc", 32'(lc_a), 32'd0);

        // Auto pass after reset release
        rst = 1'b0;
        tick();
        beat_a("auto0", 2'd0, 32'd5);
        chk("auto0.busy", 32'(busy_a), 32'd1);
        chk("ovr_par0", if_b.cfg_data, 32'd7);
        chk("manual_idle", 32'(if_c.cfg_valid), 32'd0);
        tick();
        beat_a("auto1", 2'd1, 32'd9);
        chk("ovr_par1", if_b.cfg_data, 32'd33);
        tick();
        beat_a("auto2", 2'd2, 32'd0);
        tick();
        beat_a("auto3", 2'd3, 32'd0);
        tick();
        chk("auto.done", 32'(done_a), 32'd1);
        chk("auto.busy", 32'(busy_a), 32'd0);
        chk("auto.valid", 32'(if_a.cfg_valid), 32'd0);
        chk("auto.lc", 32'(lc_a), 32'd1);
        chk("par.lc", 32'(lc_b), 32'd1);
        tick();
        chk("auto.done_clr", 32'(done_a), 32'd0);
        chk("auto.stay_idle", 32'(if_a.cfg_valid), 32'd0);

        // Stall on beat 1 with an override of word 1 during the stall
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("start.lat", 32'(if_a.cfg_valid), 32'd0);
        tick();
        beat_a("st0", 2'd0, 32'd5);
        tick();
        beat_a("st1", 2'd1, 32'd9);
        if_a.cfg_ready = 1'b0;
        ovr_we_a = 1'b1;
        ovr_addr_a = 2'd1;
        ovr_data_a = 32'h55;
        tick();
        ovr_we_a = 1'b0;
        beat_a("stall1", 2'd1, 32'd9);
        tick();
        beat_a("stall2", 2'd1, 32'd9);
        tick();
        beat_a("stall3", 2'd1, 32'd9);
        if_a.cfg_ready = 1'b1;
        tick();
        beat_a("st2", 2'd2, 32'd0);
        tick();
        beat_a("st3", 2'd3, 32'd0);
        tick();
        chk("st.done", 32'(done_a), 32'd1);
        chk("st.lc", 32'(lc_a), 32'd2);
        tick();
        beat_a("rep0", 2'd0, 32'd5);
        tick();
        beat_a("rep1", 2'd1, 32'h55);
        tick();
        tick();
        tick();
        chk("rep.done", 32'(done_a), 32'd1);
        chk("rep.lc", 32'(lc_a), 32'd3);
        tick();
        chk("rep.idle", 32'(if_a.cfg_valid), 32'd0);

        // Override in idle on the manual instance
        ovr_we_c = 1'b1;
        ovr_addr_c = 2'd3;
        ovr_data_c = 32'hAB;
        tick();
        ovr_we_c = 1'b0;
        chk("ovr.lat", 32'(if_c.cfg_valid), 32'd0);
        tick();
        beat_c("ovr0", 2'd0, 32'd5);
        tick();
        tick();
        tick();
        beat_c("ovr3", 2'd3, 32'hAB);
        tick();
        chk("ovr.done", 32'(done_c), 32'd1);
        chk("ovr.lc", 32'(lc_c), 32'd1);
        tick();
        chk("ovr.idle", 32'(if_c.cfg_valid), 32'd0);
        chk("ovr.idle_busy", 32'(busy_c), 32'd0);

        // Simultaneous start and override in idle
        start_c = 1'b1;
        ovr_we_c = 1'b1;
        ovr_addr_c = 2'd0;
        ovr_data_c = 32'h77;
        tick();
        start_c = 1'b0;
        ovr_we_c = 1'b0;
        tick();
        beat_c("sim0", 2'd0, 32'h77);
        tick();
        tick();
        tick();
        tick();
        chk("sim.done", 32'(done_c), 32'd1);
        chk("sim.lc", 32'(lc_c), 32'd2);
        tick();
        chk("sim.no_extra1", 32'(if_c.cfg_valid), 32'd0);
        tick();
        chk("sim.no_extra2", 32'(if_c.cfg_valid), 32'd0);

        // Reset during beat 2
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        tick();
        tick();
        beat_a("pre_rst2", 2'd2, 32'd0);
        rst = 1'b1;
        tick();
        chk("mid_rst.valid", 32'(if_a.cfg_valid), 32'd0);
        chk("mid_rst.done", 32'(done_a), 32'd0);
        chk("mid_rst.lc", 32'(lc_a), 32'd0);
        rst = 1'b0;
        tick();
        beat_a("post0", 2'd0, 32'd5);
        tick();
        beat_a("post1", 2'd1, 32'd9);
        tick();
        tick();
        tick();
        chk("post.done", 32'(done_a), 32'd1);
        chk("post.lc", 32'(lc_a), 32'd1);

        // Saturation of the pass counter on the manual instance
        chk("sat.lc0", 32'(lc_c), 32'd0);
        for (int p = 1; p <= 258; p++) begin
            start_c = 1'b1;
            tick();
            start_c = 1'b0;
            for (int k = 0; k < 20 && !done_c; k++) begin
                tick();
            end
            if (!done_c) begin
                chk("sat.timeout", 32'(done_c), 32'd1);
            end
            if (p == 254) begin
                chk("sat.lc254", 32'(lc_c), 32'd254);
            end
            if (p == 255) begin
                chk("sat.lc255", 32'(lc_c), 32'd255);
            end
        end
        chk("sat.hold", 32'(lc_c), 32'd255);
        tick();
        chk("sat.idle", 32'(if_c.cfg_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
